// File: rtl/dmem_arbiter_if.sv
// Per-port request/completion bundle between a memory master and dmem_arbiter.
// The master drives the command and the arbiter returns grant, completion and load data.
interface dmem_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req;
  logic                  we;
  logic [DM_ADDRESS-1:0] addr;
  logic [DATA_W-1:0]     wdata;
  logic [2:0]            funct3;
  logic                  gnt;
  logic                  done;
  logic                  err;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req, we, addr, wdata, funct3,
    input  gnt, done, err, rdata
  );

  modport slave (
    input  req, we, addr, wdata, funct3,
    output gnt, done, err, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the data memory: grant -> one ACCESS cycle -> done.
// Illegal or misaligned commands are granted but never strobe the memory.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int ARB_MODE   = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dmem_arbiter_if.slave         p0,
  dmem_arbiter_if.slave         p1,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  output logic [2:0]            Funct3,
  input  logic [DATA_W-1:0]     rd
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t                state;
  logic [3:0]            starve_cnt;
  logic                  rr_ptr;
  logic                  acc_id;
  logic                  acc_we;
  logic                  acc_legal;

  logic                  p1_pri;
  logic                  gnt0;
  logic                  gnt1;
  logic                  any_gnt;
  logic                  win_we;
  logic [DM_ADDRESS-1:0] win_addr;
  logic [DATA_W-1:0]     win_wdata;
  logic [2:0]            win_f3;
  logic                  win_legal;

  // Size code and alignment check; funct3 100 (LBU) is a load-only encoding.
  function automatic logic is_legal(input logic we, input logic [2:0] f3,
                                    input logic [1:0] lo);
    case (f3)
      3'b000:  is_legal = 1'b1;
      3'b001:  is_legal = ~lo[0];
      3'b010:  is_legal = (lo == 2'b00);
      3'b100:  is_legal = ~we;
      default: is_legal = 1'b0;
    endcase
  endfunction

  assign p1_pri = (ARB_MODE == 0) ? (starve_cnt == STARVE_LIM) : rr_ptr;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (p0.req && p1.req) begin
        gnt1 = p1_pri;
        gnt0 = ~p1_pri;
      end else begin
        gnt0 = p0.req;
        gnt1 = p1.req;
      end
    end
  end

  assign p0.gnt    = gnt0;
  assign p1.gnt    = gnt1;
  assign any_gnt   = gnt0 | gnt1;
  assign win_we    = gnt1 ? p1.we     : p0.we;
  assign win_addr  = gnt1 ? p1.addr   : p0.addr;
  assign win_wdata = gnt1 ? p1.wdata  : p0.wdata;
  assign win_f3    = gnt1 ? p1.funct3 : p0.funct3;
  assign win_legal = is_legal(win_we, win_f3, win_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      rr_ptr     <= 1'b0;
      acc_id     <= 1'b0;
      acc_we     <= 1'b0;
      acc_legal  <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      a          <= '0;
      wd         <= '0;
      Funct3     <= '0;
      p0.done    <= 1'b0;
      p0.err     <= 1'b0;
      p0.rdata   <= '0;
      p1.done    <= 1'b0;
      p1.err     <= 1'b0;
      p1.rdata   <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      state <= any_gnt ? ACCESS : IDLE;

      // Memory-side outputs are registered at grant; no request path reaches them directly.
      MemRead  <= any_gnt & win_legal & ~win_we;
      MemWrite <= any_gnt & win_legal &  win_we;
      if (any_gnt) begin
        acc_id    <= gnt1;
        acc_we    <= win_we;
        acc_legal <= win_legal;
        a         <= win_addr;
        wd        <= win_wdata;
        Funct3    <= win_f3;
        rr_ptr    <= ~gnt1;
      end

      if (gnt1)
        starve_cnt <= '0;
      else if (p1.req && starve_cnt != STARVE_LIM)
        starve_cnt <= starve_cnt + 4'd1;

      // Completion for whatever was in ACCESS this cycle; rd is sampled here.
      p0.done <= (state == ACCESS) && !acc_id;
      p0.err  <= (state == ACCESS) && !acc_id && !acc_legal;
      p1.done <= (state == ACCESS) &&  acc_id;
      p1.err  <= (state == ACCESS) &&  acc_id && !acc_legal;
      if (state == ACCESS && acc_legal && !acc_we) begin
        if (acc_id) p1.rdata <= rd;
        else        p0.rdata <= rd;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one fixed-priority instance and one round-robin
// instance fed the same stimulus, checked with immediate assertions.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] rd;
  int          checks;
  int          failures;

  logic        mr0, mw0, mr1, mw1;
  logic [8:0]  a0, a1;
  logic [31:0] wd0, wd1;
  logic [2:0]  f30, f31;

  dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) pa0 ();
  dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) pa1 ();
  dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) pb0 ();
  dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) pb1 ();

  assign pb0.req    = pa0.req;
  assign pb0.we     = pa0.we;
  assign pb0.addr   = pa0.addr;
  assign pb0.wdata  = pa0.wdata;
  assign pb0.funct3 = pa0.funct3;
  assign pb1.req    = pa1.req;
  assign pb1.we     = pa1.we;
  assign pb1.addr   = pa1.addr;
  assign pb1.wdata  = pa1.wdata;
  assign pb1.funct3 = pa1.funct3;

  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .ARB_MODE(0), .STARVE_MAX(4)) dut_fp (
    .clk(clk), .rst_n(rst_n), .p0(pa0), .p1(pa1),
    .MemRead(mr0), .MemWrite(mw0), .a(a0), .wd(wd0), .Funct3(f30), .rd(rd)
  );

  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .ARB_MODE(1), .STARVE_MAX(4)) dut_rr (
    .clk(clk), .rst_n(rst_n), .p0(pb0), .p1(pb1),
    .MemRead(mr1), .MemWrite(mw1), .a(a1), .wd(wd1), .Funct3(f31), .rd(rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic req, input logic we, input logic [8:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3);
    pa0.req = req; pa0.we = we; pa0.addr = addr; pa0.wdata = wdata; pa0.funct3 = f3;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [8:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3);
    pa1.req = req; pa1.we = we; pa1.addr = addr; pa1.wdata = wdata; pa1.funct3 = f3;
  endtask

  initial begin
    logic exp_p1;
    logic prev_p1;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    rd       = 32'h0;
    drive0(1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
    drive1(1'b0, 1'b0, 9'h000, 32'h0, 3'b000);

    // Reset state, with a request pending to prove the grant is suppressed.
    #12;
    check("rst_p0_gnt",   32'(pa0.gnt),   32'd0);
    check("rst_memread",  32'(mr0),       32'd0);
    check("rst_memwrite", 32'(mw0),       32'd0);
    check("rst_a",        32'(a0),        32'd0);
    check("rst_p0_done",  32'(pa0.done),  32'd0);
    check("rst_p0_rdata", pa0.rdata,      32'd0);
    pa0.req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single LW from port 0.
    tick();
    drive0(1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
    @(negedge clk);
    check("ld_p0_gnt", 32'(pa0.gnt), 32'd1);
    check("ld_p1_gnt", 32'(pa1.gnt), 32'd0);
    tick();
    pa0.req = 1'b0;
    rd = 32'hDEAD_BEEF;
    @(negedge clk);
    check("ld_memread",  32'(mr0), 32'd1);
    check("ld_memwrite", 32'(mw0), 32'd0);
    check("ld_a",        32'(a0),  32'h010);
    check("ld_funct3",   32'(f30), 32'd2);
    tick();
    @(negedge clk);
    check("ld_done",        32'(pa0.done), 32'd1);
    check("ld_err",         32'(pa0.err),  32'd0);
    check("ld_rdata",       pa0.rdata,     32'hDEAD_BEEF);
    check("ld_idle_strobe", 32'(mr0),      32'd0);
    tick();
    @(negedge clk);
    check("ld_done_pulse", 32'(pa0.done), 32'd0);

    // Fixed priority with starvation guard: p1 wins on the 5th and 10th conflict cycle.
    rd = 32'h1234_5678;
    prev_p1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) begin
        drive0(1'b1, 1'b0, 9'h020, 32'h0, 3'b010);
        drive1(1'b1, 1'b0, 9'h040, 32'h0, 3'b010);
      end
      exp_p1 = (i == 4) || (i == 9);
      @(negedge clk);
      check($sformatf("fp_gnt0_c%0d", i), 32'(pa0.gnt), 32'(!exp_p1));
      check($sformatf("fp_gnt1_c%0d", i), 32'(pa1.gnt), 32'(exp_p1));
      if (i > 0)
        check($sformatf("fp_addr_c%0d", i), 32'(a0), prev_p1 ? 32'h040 : 32'h020);
      prev_p1 = exp_p1;
    end
    tick();
    pa0.req = 1'b0;
    pa1.req = 1'b0;
    @(negedge clk);
    check("fp_last_addr", 32'(a0), 32'h040);
    tick();
    @(negedge clk);
    check("fp_p1_done",  32'(pa1.done), 32'd1);
    check("fp_p1_rdata", pa1.rdata,     32'h1234_5678);

    // Misaligned SW on port 1: granted, no memory strobe, done with err.
    tick();
    drive1(1'b1, 1'b1, 9'h006, 32'hCAFE_0001, 3'b010);
    @(negedge clk);
    check("mis_gnt", 32'(pa1.gnt), 32'd1);
    tick();
    pa1.req = 1'b0;
    @(negedge clk);
    check("mis_memwrite", 32'(mw0), 32'd0);
    check("mis_memread",  32'(mr0), 32'd0);
    tick();
    @(negedge clk);
    check("mis_done",  32'(pa1.done), 32'd1);
    check("mis_err",   32'(pa1.err),  32'd1);
    check("mis_rdata", pa1.rdata,     32'h1234_5678);

    // Back-to-back SB then LBU from port 0 with no bubble.
    tick();
    drive0(1'b1, 1'b1, 9'h003, 32'h0000_00AB, 3'b000);
    @(negedge clk);
    check("b2b_gnt_sb", 32'(pa0.gnt), 32'd1);
    tick();
    drive0(1'b1, 1'b0, 9'h003, 32'h0, 3'b100);
    @(negedge clk);
    check("b2b_gnt_lbu",  32'(pa0.gnt), 32'd1);
    check("b2b_memwrite", 32'(mw0),     32'd1);
    check("b2b_a",        32'(a0),      32'h003);
    check("b2b_wd",       wd0,          32'h0000_00AB);
    check("b2b_f3_sb",    32'(f30),     32'd0);
    tick();
    pa0.req = 1'b0;
    rd = 32'h0000_00AB;
    @(negedge clk);
    check("b2b_memread",   32'(mr0),      32'd1);
    check("b2b_mw_off",    32'(mw0),      32'd0);
    check("b2b_f3_lbu",    32'(f30),      32'd4);
    check("b2b_done_sb",   32'(pa0.done), 32'd1);
    check("b2b_err_sb",    32'(pa0.err),  32'd0);
    check("b2b_rdata_hold", pa0.rdata,    32'h1234_5678);
    tick();
    @(negedge clk);
    check("b2b_done_lbu",  32'(pa0.done), 32'd1);
    check("b2b_rdata_lbu", pa0.rdata,     32'h0000_00AB);
    check("b2b_mr_off",    32'(mr0),      32'd0);

    // Reset asserted in the middle of an ACCESS cycle.
    tick();
    drive0(1'b1, 1'b1, 9'h100, 32'h0000_0055, 3'b010);
    @(negedge clk);
    check("rmo_gnt", 32'(pa0.gnt), 32'd1);
    tick();
    pa0.req = 1'b0;
    #2;
    check("rmo_memwrite_pre", 32'(mw0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmo_memwrite_async", 32'(mw0), 32'd0);
    check("rmo_a_async",        32'(a0),  32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("rmo_no_done_a", 32'(pa0.done), 32'd0);
    tick();
    @(negedge clk);
    check("rmo_no_done_b", 32'(pa0.done), 32'd0);

    // Post-reset conflict: both instances start at port 0; round-robin alternates.
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) begin
        drive0(1'b1, 1'b0, 9'h020, 32'h0, 3'b010);
        drive1(1'b1, 1'b0, 9'h040, 32'h0, 3'b010);
      end
      @(negedge clk);
      check($sformatf("rr_gnt0_c%0d", i), 32'(pb0.gnt), 32'((i % 2) == 0));
      check($sformatf("rr_gnt1_c%0d", i), 32'(pb1.gnt), 32'((i % 2) == 1));
      check($sformatf("fp2_gnt1_c%0d", i), 32'(pa1.gnt), 32'(i == 4));
    end
    tick();
    pa0.req = 1'b0;
    pa1.req = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the data memory block.
- Port 0 is the core load/store unit; port 1 is a secondary master (debug/DMA loader).
- Accepts one request per cycle and issues it to the memory in the following cycle. Returns the completion and read data one cycle after the memory access.
- Rejects misaligned or unsupported accesses before they reach memory, and prevents port 1 from starving.

Parameters:
- DM_ADDRESS, 9, memory address width (byte address).
- DATA_W, 32, data width.
- ARB_MODE, 0, 0 = fixed priority to port 0 with starvation guard; 1 = round-robin.
- STARVE_MAX, 4, consecutive denied cycles of port 1 before it wins once (ARB_MODE=0 only); range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pN_req  in  1  request valid, N=0,1. Command must be held stable until pN_gnt.
- pN_we  in  1  1 = store, 0 = load.
- pN_addr  in  DM_ADDRESS  byte address.
- pN_wdata  in  DATA_W  store data.
- pN_funct3  in  3  access size code (instruction bits 14:12).
- pN_gnt  out  1  combinational accept, same cycle as pN_req.
- pN_done  out  1  one-cycle completion pulse.
- pN_err  out  1  valid with pN_done; access was rejected.
- pN_rdata  out  DATA_W  load result, valid with pN_done on a successful load.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- a  out  DM_ADDRESS  memory address.
- wd  out  DATA_W  memory write data.
- Funct3  out  3  access size code to memory.
- rd  in  DATA_W  memory read data; sampled at the end of the ACCESS cycle.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: MemRead, MemWrite, a, wd, Funct3, pN_done, pN_err, pN_rdata all reach 0 immediately; pN_gnt forced 0.
  - State: FSM to IDLE; starvation counter 0; round-robin pointer to port 0.
  - An in-flight access is dropped and produces no done.
- FSM states:
  - IDLE: memory strobes 0.
  - ACCESS: drives the latched command to memory for exactly one cycle.
- Transitions:
  - Any request granted → ACCESS next cycle, from either IDLE or ACCESS (back-to-back, throughput 1/cycle).
  - No grant → IDLE.
- Grant rules:
  - At most one pN_gnt per cycle. A grant is always possible when rst_n=1.
  - On grant: latch the winner's id, we, addr, wdata, funct3, and the legality result.
- ARB_MODE=0 (fixed priority with starvation guard):
  - Port 0 wins a conflict.
  - Counter increments each cycle p1_req=1 and p1 is denied. It saturates at STARVE_MAX and clears on p1 grant.
  - When counter == STARVE_MAX, p1 wins the next conflict.
- ARB_MODE=1 (round-robin): on conflict, the pointer port wins; the pointer moves to the other port after any grant.
- Legality check at grant:
  - Legal loads: funct3 000, 001, 010, 100.
  - Legal stores: 000, 001, 010.
  - LH/SH require addr[0]=0; LW/SW require addr[1:0]=0.
  - Illegal command: the ACCESS cycle keeps MemRead=MemWrite=0.
- ACCESS cycle outputs: MemRead=~we, MemWrite=we, a=addr, wd=wdata, Funct3=funct3.
- Completion:
  - The cycle after ACCESS, the winner's pN_done=1 for one cycle.
  - pN_err=1 if illegal.
  - pN_rdata is updated with rd on legal loads only; otherwise it holds its prior value.
  - Latency: gnt cycle T → memory cycle T+1 → done at T+2.
- Simultaneous events:
  - A done for one port and a gnt for either port may coincide.
  - A port may be re-granted in the same cycle its previous done is pending.
- No request combinational path to memory outputs: memory outputs come from registers only.

Test Plan:
- Single load: p0_req, we=0, addr=0x010, funct3=010, memory rd=0xDEADBEEF → p0_gnt at T, MemRead=1 a=0x010 at T+1, p0_done=1 p0_rdata=0xDEADBEEF at T+2.
- Conflict, ARB_MODE=0, STARVE_MAX=4: both ports request continuously → p0 granted 4 cycles, p1 granted on 5th, then p0 resumes; counter returns to 0.
- Conflict, ARB_MODE=1: both request 6 cycles → grants alternate p0,p1,p0,p1,p0,p1.
- Misaligned SW addr=0x006 on p1 → p1_gnt, MemWrite stays 0 in ACCESS, p1_done=1 with p1_err=1 at T+2.
- Back-to-back: p0 SB addr=0x003 wdata=0xAB at T, p0 LBU addr=0x003 at T+1 → MemWrite at T+1, MemRead at T+2, two dones at T+2 and T+3, no bubble.
- Reset mid-op: rst_n low during ACCESS → MemWrite drops to 0 asynchronously, no done after release, first post-reset grant goes to port 0.
